// File: rtl/req_arbiter_4ch_pkg.sv
// req_arbiter_4ch_pkg: shared state codes, channel sizing and grant decode helper for the request arbiters
package req_arbiter_4ch_pkg;
  localparam int NUM_CH = 4;
  localparam int CH_W = 2;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;
  function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] id);
    return NUM_CH'(1) << id;
  endfunction
endpackage

// File: rtl/req_arbiter_4ch_pick.sv
// rr_priority_pick4: combinational winner select, fixed (highest index) or round-robin from ptr
module rr_priority_pick4
  import req_arbiter_4ch_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  input  logic              mode_i,
  output logic [CH_W-1:0]   win_id_o,
  output logic              win_v_o
);
  logic [CH_W-1:0]     sh;
  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic [CH_W-1:0]     enc;
  // rotating by ptr makes the round-robin scan a plain lowest-index encode
  assign sh  = mode_i ? ptr_i : '0;
  assign dbl = {req_i, req_i} >> sh;
  assign rot = dbl[NUM_CH-1:0];
  always_comb begin
    enc = mode_i ? (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3)
                 : (rot[3] ? 2'd3 : rot[2] ? 2'd2 : rot[1] ? 2'd1 : 2'd0);
  end
  assign win_id_o = enc + sh;
  assign win_v_o  = |req_i;
endmodule

// File: rtl/req_arbiter_4ch.sv
// req_arbiter_4ch: 4-requester arbiter with grant hold, release gap and optional hold timeout
module req_arbiter_4ch
  import req_arbiter_4ch_pkg::*;
#(
  parameter bit MODE_RR  = 1'b0,
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              done_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CH_W-1:0]   gnt_id_o,
  output logic              gnt_v_o,
  output logic              busy_o,
  output logic              timeout_o
);
  state_e            state_q, state_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [CH_W-1:0]   id_q, id_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmo_q, tmo_d;
  logic [CH_W-1:0]   win_id;
  logic              win_v;
  logic              hit_max;
  logic              rel;
  rr_priority_pick4 u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .mode_i  (MODE_RR),
    .win_id_o(win_id),
    .win_v_o (win_v)
  );
  assign hit_max = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign rel     = done_i || !req_i[id_q] || hit_max;
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    last_d  = last_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (win_v) begin
        state_d = ST_GRANT;
        gnt_d   = onehot(win_id);
        id_d    = win_id;
        cnt_d   = '0;
      end
      ST_GRANT: begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
        if (rel) begin
          state_d = ST_GAP;
          gnt_d   = '0;
          id_d    = '0;
          last_d  = id_q;
          tmo_d   = hit_max && !done_i && req_i[id_q];
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
        ptr_d   = last_q + 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        id_d    = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      last_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end
  assign gnt_o     = gnt_q;
  assign gnt_id_o  = id_q;
  assign gnt_v_o   = |gnt_q;
  assign busy_o    = state_q != ST_IDLE;
  assign timeout_o = tmo_q;
endmodule
